out_mem_seq_ctrl: RTL and testbench

//  Sequencer for the 16x256 output memory behind the 4x4 systolic PE array.
//  - Waits for the array to finish a tile, then issues one 16-word burst write at addr_ptr = tile*16.
//  - Clears the PE accumulators, then repeats for NUM tiles.
//  - Streams the stored results out word-by-word through a valid/ready port.

---
 rtl/out_mem_seq_ctrl_pkg.sv | 32 +++
 rtl/out_mem_seq_ctrl_if.sv | 23 ++
 rtl/out_mem_seq_ctrl_rd_stage.sv | 32 +++
 rtl/out_mem_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_out_mem_seq_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/out_mem_seq_ctrl_pkg.sv
// Shared types, sizes and address helpers for the output-memory sequencer.
package out_mem_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned TILE_WORDS = 16;
  localparam int unsigned MEM_DEPTH  = 256;
  localparam int unsigned MAX_TILES  = MEM_DEPTH / TILE_WORDS;
  localparam int unsigned TILE_SHIFT = $clog2(TILE_WORDS);
  localparam int unsigned NT_W       = 5;
  localparam int unsigned TILE_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_PE = 3'd1,
    ST_WRITE   = 3'd2,
    ST_CLEAR   = 3'd3,
    ST_READ    = 3'd4,
    ST_FINISH  = 3'd5
  } state_e;

  // Base address of a tile burst; tile*TILE_WORDS done as a shift.
  function automatic logic [ADDR_W-1:0] tile_base(input logic [TILE_W-1:0] tile);
    return ADDR_W'(tile) << TILE_SHIFT;
  endfunction

  // Last word index of an n-tile job (n*TILE_WORDS - 1).
  function automatic logic [ADDR_W-1:0] last_word(input logic [NT_W-1:0] n);
    return (ADDR_W'(n) << TILE_SHIFT) - ADDR_W'(1);
  endfunction

endpackage

// File: rtl/out_mem_seq_ctrl_if.sv
// Memory and readback stream signals between the sequencer and its neighbours.
interface out_mem_seq_ctrl_if;
  import out_mem_pkg::*;

  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr_ptr;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;

  modport master (
    output mem_write_en, mem_addr_ptr, mem_addr_out, rd_data, rd_valid,
    input  mem_data_out, rd_ready
  );

  modport slave (
    input  mem_write_en, mem_addr_ptr, mem_addr_out, rd_data, rd_valid,
    output mem_data_out, rd_ready
  );

endinterface

// File: rtl/out_mem_seq_ctrl_rd_stage.sv
// One-entry registered valid/ready output stage for the result stream.
module out_rd_stage
  import out_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              advance_c
);

  // Register may take a new word when empty or when its word is being taken.
  assign advance_c = !rd_valid || rd_ready;

  // Output register: hold while stalled, reload or drain on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      rd_valid <= 1'b0;
    end else if (advance_c) begin
      rd_valid <= load;
      if (load) rd_data <= data_in;
    end
  end

endmodule

// File: rtl/out_mem_seq_ctrl.sv
// Sequences tile bursts from the PE array into output memory, then streams them out.
module out_mem_seq_ctrl
  import out_mem_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [NT_W-1:0] num_tiles,
  input  logic            abort,
  input  logic            pe_done,
  output logic            pe_clear,
  out_mem_seq_ctrl_if.master bus,
  output logic            busy,
  output logic            done,
  output logic            err
);

  state_e            state_q, state_d;
  logic [NT_W-1:0]   n_q, n_d;
  logic [TILE_W-1:0] tile_q, tile_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              last_loaded_q, last_loaded_d;
  logic [ADDR_W-1:0] addr_ptr_q, addr_ptr_d;
  logic              wr_en_q, wr_en_d;
  logic              pe_clear_d, busy_d, done_d, err_d;
  logic              rd_load_c, rd_flush_c, rd_advance_c;
  logic              rd_valid_w;
  logic [DATA_W-1:0] rd_data_w;
  logic [ADDR_W-1:0] last_addr_c;

  assign last_addr_c = last_word(n_q);

  // Readback output register.
  out_rd_stage u_rd_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (rd_load_c),
    .flush     (rd_flush_c),
    .data_in   (bus.mem_data_out),
    .rd_ready  (bus.rd_ready),
    .rd_data   (rd_data_w),
    .rd_valid  (rd_valid_w),
    .advance_c (rd_advance_c)
  );

  assign bus.mem_write_en = wr_en_q;
  assign bus.mem_addr_ptr = addr_ptr_q;
  assign bus.mem_addr_out = rd_addr_q;
  assign bus.rd_data      = rd_data_w;
  assign bus.rd_valid     = rd_valid_w;

  // Next state, counters and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    n_d           = n_q;
    tile_d        = tile_q;
    rd_addr_d     = rd_addr_q;
    last_loaded_d = last_loaded_q;
    err_d         = 1'b0;
    rd_load_c     = 1'b0;
    rd_flush_c    = 1'b0;

    if (abort) begin
      state_d       = ST_IDLE;
      rd_flush_c    = 1'b1;
      rd_addr_d     = '0;
      last_loaded_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (num_tiles != '0 && num_tiles <= NT_W'(MAX_TILES)) begin
              n_d           = num_tiles;
              tile_d        = '0;
              rd_addr_d     = '0;
              last_loaded_d = 1'b0;
              state_d       = ST_WAIT_PE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_WAIT_PE: begin
          if (pe_done) state_d = ST_WRITE;
        end
        ST_WRITE: begin
          state_d = ST_CLEAR;
        end
        ST_CLEAR: begin
          if (NT_W'(tile_q) + NT_W'(1) == n_q) begin
            rd_addr_d     = '0;
            last_loaded_d = 1'b0;
            state_d       = ST_READ;
          end else begin
            tile_d  = tile_q + TILE_W'(1);
            state_d = ST_WAIT_PE;
          end
        end
        ST_READ: begin
          // Counter parks on the last word so no address past the job is driven.
          if (rd_advance_c && !last_loaded_q) begin
            rd_load_c = 1'b1;
            if (rd_addr_q == last_addr_c) last_loaded_d = 1'b1;
            else                          rd_addr_d     = rd_addr_q + ADDR_W'(1);
          end
          if (last_loaded_q && rd_valid_w && bus.rd_ready) state_d = ST_FINISH;
        end
        ST_FINISH: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d     = (state_d != ST_IDLE);
    wr_en_d    = (state_d == ST_WRITE);
    pe_clear_d = (state_d == ST_CLEAR);
    done_d     = (state_d == ST_FINISH);
    addr_ptr_d = (state_d == ST_WRITE) ? tile_base(tile_q) : addr_ptr_q;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      n_q           <= '0;
      tile_q        <= '0;
      rd_addr_q     <= '0;
      last_loaded_q <= 1'b0;
      addr_ptr_q    <= '0;
      wr_en_q       <= 1'b0;
      pe_clear      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      tile_q        <= tile_d;
      rd_addr_q     <= rd_addr_d;
      last_loaded_q <= last_loaded_d;
      addr_ptr_q    <= addr_ptr_d;
      wr_en_q       <= wr_en_d;
      pe_clear      <= pe_clear_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
    end
  end

endmodule

// File: tb/tb_out_mem_seq_ctrl.sv
// Randomized self-checking bench for out_mem_seq_ctrl with a queue-based result model.
module tb_out_mem_seq_ctrl;
  import out_mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [4:0] num_tiles = 5'd0;
  logic       abort = 1'b0;
  logic       pe_done = 1'b0;
  logic       pe_clear, busy, done, err;

  out_mem_seq_ctrl_if bus();

  out_mem_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_tiles (num_tiles),
    .abort     (abort),
    .pe_done   (pe_done),
    .pe_clear  (pe_clear),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Output memory and PE array results as seen by the controller.
  logic [15:0] mem [256];
  logic [15:0] pe_vals [16];
  logic [15:0] exp_q [$];

  assign bus.mem_data_out = mem[bus.mem_addr_out[7:0]];

  always @(posedge clk) begin
    if (bus.mem_write_en)
      for (int i = 0; i < 16; i++) mem[bus.mem_addr_ptr[7:0] + 8'(i)] <= pe_vals[i];
  end

  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int addr_viol = 0;
  int cur_last = 0;

  // Event counters and read-address bound watch.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (busy && int'(bus.mem_addr_out) > cur_last) addr_viol++;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    for (int i = 0; i < 16; i++) pe_vals[i] = 16'd0;
    bus.rd_ready = 1'b0;
  end

  task automatic do_start(input int n);
    @(negedge clk);
    start = 1'b1; num_tiles = 5'(n); cur_last = n * 16 - 1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL start_accept n=%0d: busy=%b err=%b, required busy=1 err=0", n, busy, err);
    end
  endtask

  task automatic do_tiles(input int n, input bit seq);
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(2, 4)) @(negedge clk);
      for (int i = 0; i < 16; i++) begin
        pe_vals[i] = seq ? 16'(t * 16 + i + 1) : 16'($urandom);
        exp_q.push_back(pe_vals[i]);
      end
      pe_done = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.mem_write_en !== 1'b1 || bus.mem_addr_ptr !== 16'(t * 16) || pe_clear !== 1'b0) begin
        fails++;
        $display("FAIL write_strobe tile=%0d: we=%b ptr=%0d clr=%b, required we=1 ptr=%0d clr=0",
                 t, bus.mem_write_en, bus.mem_addr_ptr, pe_clear, t * 16);
      end
      @(posedge clk); #1;
      checks++;
      if (pe_clear !== 1'b1 || bus.mem_write_en !== 1'b0 || bus.mem_addr_ptr !== 16'(t * 16)) begin
        fails++;
        $display("FAIL pe_clear tile=%0d: clr=%b we=%b ptr=%0d, required clr=1 we=0 ptr=%0d",
                 t, pe_clear, bus.mem_write_en, bus.mem_addr_ptr, t * 16);
      end
      pe_done = 1'b0;
    end
  endtask

  // Consumer: mode 0 always ready, 1 alternating with a 5-cycle stall, 2 random.
  task automatic do_read(input int mode, input int stop_at);
    int got = 0;
    int cyc = 0;
    logic r;
    logic hold_v = 1'b0;
    logic [15:0] hold_d = 16'd0;
    logic [15:0] e;
    while (got < stop_at && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (hold_v) begin
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== hold_d) begin
          fails++;
          $display("FAIL stall_hold word=%0d: valid=%b data=%h, required valid=1 data=%h",
                   got, bus.rd_valid, bus.rd_data, hold_d);
        end
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc >= 8 && cyc < 13) ? 1'b0 : 1'((cyc % 2) == 1);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.rd_ready = r;
      hold_v = bus.rd_valid && !r;
      hold_d = bus.rd_data;
      if (bus.rd_valid === 1'b1 && r) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL stream_extra word=%0d: data=%h, required no word", got, bus.rd_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.rd_data !== e) begin
            fails++;
            $display("FAIL stream_word idx=%0d: data=%h, required %h", got, bus.rd_data, e);
          end
        end
        got++;
      end
    end
    checks++;
    if (got < stop_at) begin
      fails++;
      $display("FAIL stream_timeout: got %0d words, required %0d", got, stop_at);
    end
  endtask

  task automatic finish_check(input int d0);
    @(negedge clk);
    bus.rd_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || bus.rd_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL finish_state: done=%b valid=%b busy=%b, required done=1 valid=0 busy=1",
               done, bus.rd_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL back_to_idle: done=%b busy=%b, required 0 0", done, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != d0 + 1 || exp_q.size() != 0 || addr_viol != 0) begin
      fails++;
      $display("FAIL job_end: done pulses=%0d left=%0d addr_viol=%0d, required 1 0 0",
               done_cnt - d0, exp_q.size(), addr_viol);
    end
  endtask

  task automatic run_job(input int n, input int mode, input bit seq);
    int d0;
    d0 = done_cnt;
    do_start(n);
    do_tiles(n, seq);
    do_read(mode, n * 16);
    finish_check(d0);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || pe_clear !== 1'b0 ||
        bus.rd_valid !== 1'b0 || bus.rd_data !== 16'd0 || bus.mem_write_en !== 1'b0 ||
        bus.mem_addr_ptr !== 16'd0 || bus.mem_addr_out !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b err=%b clr=%b valid=%b data=%h, required all 0",
               busy, done, err, pe_clear, bus.rd_valid, bus.rd_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_read;
    do_start(1);
    do_tiles(1, 1'b0);
    bus.rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.rd_valid !== 1'b1) begin
      fails++;
      $display("FAIL read_entry_valid: valid=%b, required 1", bus.rd_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bus.rd_valid !== 1'b0 || bus.rd_data !== 16'd0 || done !== 1'b0 ||
        bus.mem_addr_out !== 16'd0 || bus.mem_addr_ptr !== 16'd0) begin
      fails++;
      $display("FAIL async_reset: busy=%b valid=%b data=%h addr_out=%0d, required 0 0 0 0",
               busy, bus.rd_valid, bus.rd_data, bus.mem_addr_out);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL after_reset: busy=%b valid=%b, required 0 0", busy, bus.rd_valid);
    end
  endtask

  task automatic test_errors;
    int e0;
    e0 = err_cnt;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1; num_tiles = (k == 0) ? 5'd0 : 5'd17;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL err_pulse n=%0d: err=%b busy=%b, required err=1 busy=0", num_tiles, err, busy);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL err_width: err=%b busy=%b, required 0 0", err, busy);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (err_cnt != e0 + 2) begin
      fails++;
      $display("FAIL err_count: pulses=%0d, required 2", err_cnt - e0);
    end
    // A start while busy must neither flag nor restart the job.
    do_start(1);
    @(negedge clk);
    start = 1'b1; num_tiles = 5'd0;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL start_while_busy: err=%b busy=%b, required err=0 busy=1", err, busy);
    end
    begin
      int d0;
      d0 = done_cnt;
      do_tiles(1, 1'b0);
      do_read(2, 16);
      finish_check(d0);
    end
  endtask

  task automatic test_abort;
    int d0;
    d0 = done_cnt;
    do_start(3);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_wait_pe: busy=%b valid=%b, required 0 0", busy, bus.rd_valid);
    end
    do_start(2);
    do_tiles(2, 1'b0);
    do_read(0, 10);
    @(negedge clk);
    bus.rd_ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || bus.rd_valid !== 1'b0) begin
      fails++;
      $display("FAIL abort_read: busy=%b valid=%b, required 0 0", busy, bus.rd_valid);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      fails++;
      $display("FAIL abort_no_done: done pulses=%0d, required 0", done_cnt - d0);
    end
    exp_q.delete();
    run_job(2, 2, 1'b0);
  endtask

  initial begin
    test_reset();
    test_reset_mid_read();
    run_job(1, 0, 1'b1);
    run_job(16, 0, 1'b0);
    run_job(2, 1, 1'b0);
    test_errors();
    test_abort();
    run_job($urandom_range(3, 6), 2, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
